// File: rtl/imm_encode.sv
// imm_encode: packs a 32-bit immediate into the I/S/B/J/U immediate fields of a
// base instruction word (inverse of the core's extend unit). One registered
// encode stage feeding a 2-entry FIFO, valid/ready on both sides, range check
// with a saturating error counter.
// Optional build macro IMM_ENC_STRICT_EN: out-of-range requests are counted but
// dropped instead of being emitted with out_err set.
module imm_encode #(
  parameter int ERR_CNT_W = 16,
  parameter int DEPTH     = 2   // fixed at 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_immsrc,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } ent_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  ent_t               mem [DEPTH];
  logic               rd_ptr, wr_ptr;
  logic [1:0]         cnt;
  logic               live;     // low during reset, high from first edge after release
  logic [31:0]        mask, field, enc;
  logic               bad;
  logic signed [31:0] simm;
  logic               acc, pop, push;
  ent_t               ent;

  assign simm = $signed(in_imm);

  // Field placement and legality for the selected immediate type.
  always_comb begin
    mask  = '0;
    field = '0;
    bad   = 1'b1;
    case (in_immsrc)
      3'b000: begin // I
        mask  = 32'hFFF0_0000;
        field = {in_imm[11:0], 20'b0};
        bad   = !(simm >= -32'sd2048 && simm <= 32'sd2047);
      end
      3'b001: begin // S
        mask  = 32'hFE00_0F80;
        field = {in_imm[11:5], 13'b0, in_imm[4:0], 7'b0};
        bad   = !(simm >= -32'sd2048 && simm <= 32'sd2047);
      end
      3'b010: begin // B
        mask  = 32'hFE00_0F80;
        field = {in_imm[12], in_imm[10:5], 13'b0, in_imm[4:1], in_imm[11], 7'b0};
        bad   = !(simm >= -32'sd4096 && simm <= 32'sd4094 && !in_imm[0]);
      end
      3'b011: begin // J
        mask  = 32'hFFFF_F000;
        field = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'b0};
        bad   = !(simm >= -32'sd1048576 && simm <= 32'sd1048574 && !in_imm[0]);
      end
      3'b100: begin // U: unshifted 20-bit value, same as extend
        mask  = 32'hFFFF_F000;
        field = {in_imm[19:0], 12'b0};
        bad   = !(simm >= -32'sd524288 && simm <= 32'sd524287);
      end
      default: begin // invalid type: base passes through, always an error
        mask  = '0;
        field = '0;
        bad   = 1'b1;
      end
    endcase
  end

  assign enc      = (in_base & ~mask) | field;
  assign in_ready = live && (cnt != FULL);
  assign acc      = in_valid && in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop      = out_valid && out_ready;

`ifdef IMM_ENC_STRICT_EN
  assign push = acc && !bad;
  assign ent  = '{err: 1'b0, instr: enc};
`else
  assign push = acc;
  assign ent  = '{err: bad, instr: enc};
`endif

  assign out_instr = mem[rd_ptr].instr;
  assign out_err   = mem[rd_ptr].err;

  // FIFO storage, pointers, occupancy and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live      <= 1'b0;
      cnt       <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      err_count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      live <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      if (acc && bad && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed vector table, backpressure / streaming /
// reset sequences, and randomized traffic against a bit-mapping reference model.
module tb_imm_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_immsrc = '0;
  logic [31:0] in_imm = '0, in_base = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  imm_encode #(.ERR_CNT_W(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_immsrc(in_immsrc),
    .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

`ifdef IMM_ENC_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  int tests = 0, fails = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask

  // ---------------- reference model ----------------
  // Which immediate bit lands in instruction bit p, or -1 if p is not an imm bit.
  function automatic int map_bit(input logic [2:0] t, input int p);
    case (t)
      3'd0: return (p >= 20) ? p - 20 : -1;
      3'd1: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
        return -1;
      end
      3'd2: begin
        if (p == 31) return 12;
        if (p == 7) return 11;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        return -1;
      end
      3'd3: begin
        if (p == 31) return 20;
        if (p == 20) return 11;
        if (p >= 21) return p - 20;
        if (p >= 12) return p;
        return -1;
      end
      3'd4: return (p >= 12) ? p - 12 : -1;
      default: return -1;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] t, input logic [31:0] imm);
    longint v = longint'($signed(imm));
    case (t)
      3'd0, 3'd1: return v >= -2048 && v <= 2047;
      3'd2:       return v >= -4096 && v <= 4094 && (v % 2 == 0);
      3'd3:       return v >= -1048576 && v <= 1048574 && (v % 2 == 0);
      3'd4:       return v >= -524288 && v <= 524287;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] t, input logic [31:0] imm,
                                           input logic [31:0] base);
    logic [31:0] w = base;
    for (int p = 0; p < 32; p++) begin
      int s = map_bit(t, p);
      if (s >= 0) w[p] = imm[s];
    end
    return w;
  endfunction

  // extend: gather the fields back and sign-extend from the top field bit.
  function automatic logic [31:0] ref_extend(input logic [2:0] t, input logic [31:0] w);
    logic [31:0] r = '0;
    int top;
    for (int p = 0; p < 32; p++) begin
      int s = map_bit(t, p);
      if (s >= 0) r[s] = w[p];
    end
    top = (t == 3'd2) ? 12 : (t == 3'd3) ? 20 : (t == 3'd4) ? 19 : 11;
    for (int i = top + 1; i < 32; i++) r[i] = r[top];
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  src;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int unsigned m_errs = 0;
  bit mon_en = 1'b0;

  // Inputs change at posedge+1, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      bit   lg;
      chk("sb_out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("sb_err_count", {16'b0, err_count}, m_errs);
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_instr", out_instr, e.instr);
        chk("sb_err", {31'b0, out_err}, {31'b0, e.err});
        if (!e.err) chk("roundtrip", ref_extend(e.src, out_instr), e.imm);
      end
      if (in_valid && in_ready) begin
        lg = ref_legal(in_immsrc, in_imm);
        if (!lg && m_errs != 32'd65535) m_errs++;
        if (lg || !STRICT)
          q.push_back('{ref_word(in_immsrc, in_imm, in_base), !lg, in_immsrc, in_imm});
      end
    end
  end

  // ---------------- drivers ----------------
  int  stalls_g;
  bit  rand_rdy = 1'b0;

  always @(posedge clk) begin
    #2;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
  task automatic send(input logic [2:0] s, input logic [31:0] imm, input logic [31:0] base);
    in_immsrc = s; in_imm = imm; in_base = base; in_valid = 1'b1;
    stalls_g = 0;
    @(negedge clk);
    while (!in_ready && stalls_g < 100) begin
      stalls_g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
      in_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_legal(input logic [2:0] t);
    case (t)
      3'd0, 3'd1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd2:       return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
      3'd3:       return (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      default:    return 32'($urandom_range(0, 1048575)) - 32'd524288;
    endcase
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    m_errs = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm, base, instr;
    logic        err;
  } vec_t;

  vec_t vt[17];

  initial begin
    int esum;
    vt[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0};
    vt[1]  = '{3'd1, 32'd8,         32'h0000_2023, 32'h0000_2423, 1'b0};
    vt[2]  = '{3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0};
    vt[3]  = '{3'd3, 32'd8,         32'h0000_006F, 32'h0080_006F, 1'b0};
    vt[4]  = '{3'd4, 32'h15,        32'h0000_03B7, 32'h0001_53B7, 1'b0};
    vt[5]  = '{3'd2, 32'd3,         32'h0000_0063, 32'h0000_0163, 1'b1};
    vt[6]  = '{3'd0, 32'd2048,      32'h0000_0013, 32'h8000_0013, 1'b1};
    vt[7]  = '{3'd0, 32'd2047,      32'h0,         32'h7FF0_0000, 1'b0};
    vt[8]  = '{3'd0, 32'hFFFF_F800, 32'h0,         32'h8000_0000, 1'b0};
    vt[9]  = '{3'd2, 32'd4094,      32'h0,         32'h7E00_0F80, 1'b0};
    vt[10] = '{3'd2, 32'd4096,      32'h0,         32'h8000_0000, 1'b1};
    vt[11] = '{3'd3, 32'hFFF0_0000, 32'h0,         32'h8000_0000, 1'b0};
    vt[12] = '{3'd4, 32'h0008_0000, 32'h0,         32'h8000_0000, 1'b1};
    vt[13] = '{3'd5, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b1};
    vt[14] = '{3'd1, 32'hFFFF_FFFF, 32'h0,         32'hFE00_0F80, 1'b0};
    vt[15] = '{3'd3, 32'h000F_FFFE, 32'h0,         32'h7FFF_F000, 1'b0};
    vt[16] = '{3'd4, 32'hFFF8_0000, 32'h0,         32'h8000_0000, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'b0, out_err}, 32'd0);
    chk("rst_err_count", {16'b0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rel_in_ready_post_edge", {31'b0, in_ready}, 32'd1);
    mon_en = 1'b1;

    // directed table, one request at a time into an empty buffer
    esum = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(vt[i].src, vt[i].imm, vt[i].base);
      in_valid = 1'b0;
      esum += int'(vt[i].err);
      if (STRICT && vt[i].err) begin
        chk($sformatf("vec%0d_dropped", i), {31'b0, out_valid}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_instr", i), out_instr, vt[i].instr);
        chk($sformatf("vec%0d_err", i), {31'b0, out_err}, {31'b0, vt[i].err && !STRICT});
      end
      chk($sformatf("vec%0d_err_count", i), {16'b0, err_count}, esum);
      @(posedge clk); #1;
    end

    // backpressure: two fit, third waits, FIFO order on release
    out_ready = 1'b0;
    send(3'd0, 32'd1, 32'h13);
    send(3'd0, 32'd2, 32'h13);
    in_imm = 32'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
      chk("bp_head_stable", out_instr, ref_word(3'd0, 32'd1, 32'h13));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd0, 32'd3, 32'h13);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [2:0] t = 3'($urandom_range(0, 4));
      send(t, rand_legal(t), $urandom);
      chk("stream_stall", stalls_g, 32'd0);
      chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // randomized mix with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  t = 3'($urandom_range(0, 7));
      logic [31:0] v;
      case ($urandom_range(0, 3))
        0, 1:    v = rand_legal(t);
        2:       v = $urandom;
        default: v = rand_legal(t) + 32'($urandom_range(0, 2)) * 32'h800;
      endcase
      send(t, v, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("rand_drained", {31'b0, out_valid}, 32'd0);

    // asynchronous reset with two buffered entries and err_count 5
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(3'd7, 32'd0, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'd0, 32'd10, 32'h13);
    send(3'd0, 32'd11, 32'h13);
    in_valid = 1'b0;
    chk("pre_rst_err_count", {16'b0, err_count}, 32'd5);
    chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    q.delete();
    m_errs = 0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_err_count", {16'b0, err_count}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);
    send(3'd4, 32'h15, 32'h3B7);
    in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_instr", out_instr, 32'h0001_53B7);
    repeat (3) @(posedge clk);
    #1;

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule

// File: doc/imm_encode.md
Name: imm_encode

Overview:
- Inverse of the core's `extend` unit: packs a 32-bit immediate into the immediate bit positions of a base instruction word.
- Uses the same `immsrc` encoding as `extend`.
- Sits in the instruction-generation path (self-test / boot-code generator, assembler-in-hardware) ahead of instruction memory writes.
- Registered encode stage, 2-entry output buffer, valid/ready handshakes on both sides, range checking with a saturating error counter.

Parameters:
- `ERR_CNT_W`, 16, width of the saturating error counter.
- `DEPTH`, 2, output buffer entries; fixed at 2, other values unsupported.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  block can accept a request this cycle.
- `in_immsrc`  input  3  000 I, 001 S, 010 B, 011 J, 100 U; 101-111 invalid.
- `in_imm`  input  32  signed immediate, two's complement.
- `in_base`  input  32  instruction word; immediate bit positions ignored/overwritten.
- `out_valid`  output  1  encoded word available.
- `out_ready`  input  1  consumer takes word when `out_valid` and `out_ready` are both 1.
- `out_instr`  output  32  encoded instruction.
- `out_err`  output  1  entry failed range/format check.
- `err_count`  output  `ERR_CNT_W`  errors accepted since reset, saturating.

Behaviour:
- Reset (async assert, sync deassert):
  - buffer empty; `out_valid`=0, `out_instr`=0, `out_err`=0, `err_count`=0.
  - `in_ready`=0 while `rst_n`=0, 1 from the first edge after release.
- Accept: at a rising edge with `in_valid`=1 and `in_ready`=1. `in_ready` = (stored entries < 2); it is not combinationally dependent on `out_ready`.
- Latency: accepted at edge N means `out_valid`=1 after edge N with the encoded word (1 cycle) when the buffer was empty. Ordering is FIFO.
- Push and pop on the same edge with count 1: count stays 1, the new word follows the popped one. At count 2, a pop frees `in_ready` for the next cycle only.
- Encoding: start from `in_base`, clear the immediate positions of the selected type, then OR in:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1].
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1].
  - U: [31:12]=imm[19:0], the unshifted 20-bit value, matching `extend`.
  - Invalid type: `in_base` passed unchanged.
- Legal ranges (error if violated):
  - I/S: −2048..2047.
  - B: −4096..4094 and imm[0]=0.
  - J: −1048576..1048574 and imm[0]=0.
  - U: −524288..524287.
  - `immsrc` 101-111: always error.
- On error the word is still encoded from the truncated low bits and `out_err`=1 travels with the entry.
- `err_count` increments by 1 per accepted erroneous request and holds at all-ones.
- Round-trip guarantee: for any legal request, `extend(out_instr, immsrc)` == `in_imm`.
- Outputs `out_instr`/`out_err` are stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation discards all buffered entries immediately.

Optional Feature:
- Macro: `IMM_ENC_STRICT_EN`.
- Defined: erroneous requests are accepted, counted in `err_count`, and dropped (never enter the buffer); `out_err` is tied to 0.
- Undefined: erroneous requests are emitted with `out_err`=1 as described above.

Test Plan:
- I, imm=−1 (0xFFFFFFFF), base 0x00000013 -> `out_instr`=0xFFF00013, `out_err`=0, `out_valid` one cycle after accept.
- S imm=8, base 0x00002023 -> 0x00002423. B imm=−4, base 0x00000063 -> 0xFE000EE3. J imm=8, base 0x0000006F -> 0x0080006F. U imm=0x15, base 0x000003B7 -> 0x000153B7.
- B imm=3 (odd), then I imm=2048 -> both `out_err`=1, `err_count`=2. With `IMM_ENC_STRICT_EN`: no `out_valid`, `err_count`=2.
- `out_ready`=0, drive 3 back-to-back I requests (imm 1,2,3) -> two accepted, `in_ready`=0. Raise `out_ready` -> words with imm 1,2,3 delivered in order, no loss or duplication.
- `out_ready`=1, streaming request every cycle -> one word per cycle after the first, `in_ready` stays 1.
- Assert `rst_n`=0 with 2 entries buffered and `err_count`=5 -> `out_valid`=0, `err_count`=0 immediately (asynchronous); first output after release is from a new request.
